vga_sync_gen: RTL

- Produces 640x480@60 Hz VGA timing for the display pipeline.
- Divides the system clock down to a pixel-rate enable.
- Runs horizontal/vertical counters and emits pix_x/pix_y, video_on, hsync/vsync and a frame pulse.
- Sits directly upstream of the text generator and RGB output mux, which consume pix_x/pix_y and video_on every clock.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/pixel_tick_gen.sv | 28 ++
 rtl/vga_sync_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and pixel-position types for the
// sync generator and the text generator.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    typedef logic [CNT_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pix_pos_t;

    // Inclusive window test used for the sync pulses.
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock into a one-clk pixel enable every CLK_DIV clks.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_cnt <= '0;
        else if (div_cnt == LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DW'(1);
    end

    // Gated by reset so the enable drops immediately on assertion and, for
    // CLK_DIV=1, is already high in the first clk after release.
    assign p_tick = reset & (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel divider, h/v counters, registered syncs,
// visible-area flag and end-of-frame pulse.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             reset,
    output logic             p_tick,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_MAX = coord_t'(H_TOTAL - 1);
    localparam coord_t V_MAX = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS = coord_t'(V_DISPLAY);
    localparam coord_t HS_LO = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_HI = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_HI = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed counter range");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be 1..16");
        end
    endgenerate

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    pix_pos_t pos_q, pos_d;
    logic     x_last, y_last;
    logic     hsync_q, vsync_q;

    assign x_last = (pos_q.x == H_MAX);
    assign y_last = (pos_q.y == V_MAX);

    always_comb begin
        pos_d = pos_q;
        if (p_tick) begin
            if (x_last) begin
                pos_d.x = '0;
                pos_d.y = y_last ? '0 : pos_q.y + coord_t'(1);
            end else begin
                pos_d.x = pos_q.x + coord_t'(1);
            end
        end
    end

    // Syncs decode the next position so they change on the same edge as the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            pos_q   <= pos_d;
            hsync_q <= ~in_window(pos_d.x, HS_LO, HS_HI);
            vsync_q <= ~in_window(pos_d.y, VS_LO, VS_HI);
        end
    end

    assign pix_x      = pos_q.x;
    assign pix_y      = pos_q.y;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = (pos_q.x < H_VIS) && (pos_q.y < V_VIS);
    assign frame_tick = p_tick & x_last & y_last;

endmodule
